// File: rtl/ptp_tx_req_arb.sv
// Fixed-priority arbiter between the PTP message requesters and the TX frame builder.
// One command in flight at a time: grant, issue, wait for done or timeout, ack, gap.
module ptp_tx_req_arb #(
  parameter int unsigned PORT_NUM    = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_announce_req,
  input  logic                i_sync_req,
  input  logic                i_follow_up_req,
  input  logic                i_pdelayreq_req,
  input  logic                i_pdelayresp_req,
  input  logic                i_pdelayresp_fw_req,
  input  logic [PORT_NUM-1:0] i_announce_send_port,
  input  logic [PORT_NUM-1:0] i_sync_send_port,
  input  logic [PORT_NUM-1:0] i_follow_up_send_port,
  input  logic [PORT_NUM-1:0] i_pdelay_req_send_port,
  input  logic [PORT_NUM-1:0] i_pdelay_resp_send_port,
  input  logic [PORT_NUM-1:0] i_pdelay_resp_followup_send_port,
  output logic                o_announce_ack,
  output logic                o_sync_ack,
  output logic                o_follow_up_ack,
  output logic                o_pdelayreq_ack,
  output logic                o_pdelayresp_ack,
  output logic                o_pdelayresp_fw_ack,
  output logic                o_build_valid,
  output logic [2:0]          o_build_type,
  output logic [PORT_NUM-1:0] o_build_port,
  input  logic                i_build_ready,
  input  logic                i_build_done,
  output logic                o_busy,
  output logic                o_timeout_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, ACK, GAP} state_t;

  localparam logic [12:0] WAIT_LAST = 13'(TIMEOUT_CYC - 1);

  state_t              state;
  logic [12:0]         wait_cnt;
  logic [5:0]          ack;
  logic                armed;
  logic                req_any;
  logic [2:0]          gnt_type;
  logic [PORT_NUM-1:0] gnt_port;

  always_comb begin
    req_any  = 1'b1;
    gnt_type = 3'd0;
    gnt_port = '0;
    if (i_pdelayresp_req) begin
      gnt_type = 3'd4;
      gnt_port = i_pdelay_resp_send_port;
    end else if (i_pdelayresp_fw_req) begin
      gnt_type = 3'd5;
      gnt_port = i_pdelay_resp_followup_send_port;
    end else if (i_sync_req) begin
      gnt_type = 3'd1;
      gnt_port = i_sync_send_port;
    end else if (i_follow_up_req) begin
      gnt_type = 3'd2;
      gnt_port = i_follow_up_send_port;
    end else if (i_pdelayreq_req) begin
      gnt_type = 3'd3;
      gnt_port = i_pdelay_req_send_port;
    end else if (i_announce_req) begin
      gnt_type = 3'd0;
      gnt_port = i_announce_send_port;
    end else begin
      req_any = 1'b0;
    end
  end

  // o_build_type/o_build_port double as the latched command for the whole transaction.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      ack           <= '0;
      armed         <= 1'b0;
      o_build_valid <= 1'b0;
      o_build_type  <= '0;
      o_build_port  <= '0;
      o_busy        <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      armed         <= 1'b1;
      ack           <= '0;
      o_timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          // armed holds off any grant on the first edge after reset release
          if (armed && req_any) begin
            o_build_type <= gnt_type;
            o_build_port <= gnt_port;
            o_busy       <= 1'b1;
            if (gnt_port == '0) begin
              state <= ACK;
              ack   <= 6'b000001 << gnt_type;
            end else begin
              state         <= ISSUE;
              o_build_valid <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (i_build_ready) begin
            state         <= WAIT_DONE;
            o_build_valid <= 1'b0;
            wait_cnt      <= '0;
          end
        end
        WAIT_DONE: begin
          if (i_build_done) begin
            state <= ACK;
            ack   <= 6'b000001 << o_build_type;
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= ACK;
            ack           <= 6'b000001 << o_build_type;
            o_timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 13'd1;
          end
        end
        ACK: begin
          state <= GAP;
        end
        GAP: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          o_busy        <= 1'b0;
          o_build_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_announce_ack      = ack[0];
  assign o_sync_ack          = ack[1];
  assign o_follow_up_ack     = ack[2];
  assign o_pdelayreq_ack     = ack[3];
  assign o_pdelayresp_ack    = ack[4];
  assign o_pdelayresp_fw_ack = ack[5];

endmodule
